// File: rtl/ibex_pkg.sv
// Shared types for the RVFI hardware trace sink: the captured record layout
// and the serialiser state encoding.
package ibex_pkg;

    localparam int unsigned TRACE_BEATS = 4;

    typedef struct packed {
        logic [7:0]  order8;
        logic [4:0]  rd_addr;
        logic        trap;
        logic        intr;
        logic [1:0]  mode;
        logic        drop;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] rd_wdata;
    } trace_rec_t;

    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_BEAT = 1'b1
    } ser_state_e;

    // Beat 0 of a record: order, destination, flags, rd_we and the loss marker.
    function automatic logic [31:0] trace_header(input trace_rec_t rec);
        return {rec.order8, rec.rd_addr, rec.trap, rec.intr, rec.mode,
                (rec.rd_addr != 5'd0), rec.drop, 13'd0};
    endfunction

endpackage

// File: rtl/ibex_trace_rec_fifo.sv
// Synchronous record FIFO with flop storage and a combinationally read head.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module ibex_trace_rec_fifo
    import ibex_pkg::*;
#(
    parameter int unsigned Depth = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push,
    input  trace_rec_t wdata,
    input  logic       pop,
    output trace_rec_t head,
    output logic       full,
    output logic       empty,
    output logic       single
);

    localparam int unsigned AW = $clog2(Depth);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] fill;
    trace_rec_t  mem [Depth];

    assign fill   = wr_ptr - rd_ptr;
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign single = (fill == {{AW{1'b0}}, 1'b1});
    assign head   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/ibex_rvfi_trace_packer.sv
// RVFI trace sink: captures one record per retirement, queues it, and streams
// each record as four 32-bit beats on a valid/ready port with loss accounting.
module ibex_rvfi_trace_packer
    import ibex_pkg::*;
#(
    parameter int unsigned RecDepth = 8,
    parameter int unsigned DropCntW = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                trace_en_i,
    input  logic                rvfi_valid,
    input  logic [63:0]         rvfi_order,
    input  logic [31:0]         rvfi_insn,
    input  logic                rvfi_trap,
    input  logic                rvfi_intr,
    input  logic [1:0]          rvfi_mode,
    input  logic [4:0]          rvfi_rd_addr,
    input  logic [31:0]         rvfi_rd_wdata,
    input  logic [31:0]         rvfi_pc_rdata,
    output logic                trace_valid_o,
    input  logic                trace_ready_i,
    output logic [31:0]         trace_data_o,
    output logic                trace_last_o,
    input  logic                drop_cnt_clr_i,
    output logic [DropCntW-1:0] drop_cnt_o,
    output logic                fifo_empty_o
);

    ser_state_e    state;
    logic [1:0]    beat_idx;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_single;
    logic          push;
    logic          pop;
    logic          drop;
    logic          handshake;
    logic          drop_pending;
    trace_rec_t    rec_in;
    trace_rec_t    head;

    logic unused_order;
    assign unused_order = ^rvfi_order[63:8];

    assign handshake = trace_valid_o & trace_ready_i;
    assign pop       = handshake & (beat_idx == 2'(TRACE_BEATS - 1));
    assign push      = rvfi_valid & trace_en_i & (~fifo_full | pop);
    assign drop      = rvfi_valid & trace_en_i & ~push;

    always_comb begin
        rec_in          = '0;
        rec_in.order8   = rvfi_order[7:0];
        rec_in.rd_addr  = rvfi_rd_addr;
        rec_in.trap     = rvfi_trap;
        rec_in.intr     = rvfi_intr;
        rec_in.mode     = rvfi_mode;
        rec_in.drop     = drop_pending;
        rec_in.pc       = rvfi_pc_rdata;
        rec_in.insn     = rvfi_insn;
        rec_in.rd_wdata = (rvfi_rd_addr == 5'd0) ? '0 : rvfi_rd_wdata;
    end

    ibex_trace_rec_fifo #(
        .Depth(RecDepth)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .wdata (rec_in),
        .pop   (pop),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .single(fifo_single)
    );

    assign fifo_empty_o = fifo_empty;

    // Saturating loss counter; a clear coinciding with a drop leaves one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt_o <= '0;
        end else if (drop_cnt_clr_i) begin
            drop_cnt_o <= DropCntW'(drop);
        end else if (drop && (drop_cnt_o != '1)) begin
            drop_cnt_o <= drop_cnt_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_pending <= 1'b0;
        end else if (drop) begin
            drop_pending <= 1'b1;
        end else if (push) begin
            drop_pending <= 1'b0;
        end
    end

    // IDLE leaves on the push itself so BEAT coincides with a non-empty FIFO,
    // giving beat 0 the cycle after capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= SER_IDLE;
            beat_idx <= '0;
        end else begin
            case (state)
                SER_IDLE: begin
                    beat_idx <= '0;
                    if (push) begin
                        state <= SER_BEAT;
                    end
                end
                SER_BEAT: begin
                    if (handshake) begin
                        if (beat_idx == 2'(TRACE_BEATS - 1)) begin
                            beat_idx <= '0;
                            if (fifo_single && !push) begin
                                state <= SER_IDLE;
                            end
                        end else begin
                            beat_idx <= beat_idx + 2'd1;
                        end
                    end
                end
                default: begin
                    state    <= SER_IDLE;
                    beat_idx <= '0;
                end
            endcase
        end
    end

    assign trace_valid_o = (state == SER_BEAT);
    assign trace_last_o  = trace_valid_o & (beat_idx == 2'(TRACE_BEATS - 1));

    always_comb begin
        trace_data_o = '0;
        if (trace_valid_o) begin
            case (beat_idx)
                2'd0:    trace_data_o = trace_header(head);
                2'd1:    trace_data_o = head.pc;
                2'd2:    trace_data_o = head.insn;
                default: trace_data_o = head.rd_wdata;
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_rvfi_trace_packer.sv
// Scoreboard bench for the RVFI trace packer: stimulus queues expected beats,
// a negedge monitor pops and compares on every handshake.
module tb_ibex_rvfi_trace_packer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        trace_en_i;
    logic        rvfi_valid;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn;
    logic        rvfi_trap;
    logic        rvfi_intr;
    logic [1:0]  rvfi_mode;
    logic [4:0]  rvfi_rd_addr;
    logic [31:0] rvfi_rd_wdata;
    logic [31:0] rvfi_pc_rdata;
    logic        trace_valid_o;
    logic        trace_ready_i;
    logic [31:0] trace_data_o;
    logic        trace_last_o;
    logic        drop_cnt_clr_i;
    logic [15:0] drop_cnt_o;
    logic        fifo_empty_o;

    always #5 clk_i = ~clk_i;

    ibex_rvfi_trace_packer #(
        .RecDepth(8),
        .DropCntW(16)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .trace_en_i    (trace_en_i),
        .rvfi_valid    (rvfi_valid),
        .rvfi_order    (rvfi_order),
        .rvfi_insn     (rvfi_insn),
        .rvfi_trap     (rvfi_trap),
        .rvfi_intr     (rvfi_intr),
        .rvfi_mode     (rvfi_mode),
        .rvfi_rd_addr  (rvfi_rd_addr),
        .rvfi_rd_wdata (rvfi_rd_wdata),
        .rvfi_pc_rdata (rvfi_pc_rdata),
        .trace_valid_o (trace_valid_o),
        .trace_ready_i (trace_ready_i),
        .trace_data_o  (trace_data_o),
        .trace_last_o  (trace_last_o),
        .drop_cnt_clr_i(drop_cnt_clr_i),
        .drop_cnt_o    (drop_cnt_o),
        .fifo_empty_o  (fifo_empty_o)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [32:0] exp_q[$];
    logic        hold_v = 1'b0;
    logic [32:0] hold_d;
    logic [32:0] exp_beat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] hdr(input logic [7:0] ord, input logic [4:0] rd,
                                        input logic trap, input logic intr,
                                        input logic [1:0] mode, input logic drp);
        return {ord, rd, trap, intr, mode, (rd != 5'd0), drp, 13'd0};
    endfunction

    // Monitor: scoreboard compare on handshakes, stability check while stalled.
    always @(negedge clk_i) begin
        if (rst_i) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid", 64'(trace_valid_o), 64'd1);
                check("hold_data_last", 64'({trace_last_o, trace_data_o}), 64'(hold_d));
            end
            if (trace_valid_o && trace_ready_i) begin
                hold_v = 1'b0;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL extra_beat: got data %0h last %0b, expected no beat", trace_data_o, trace_last_o);
                end else begin
                    exp_beat = exp_q.pop_front();
                    check("beat_data", 64'(trace_data_o), 64'(exp_beat[31:0]));
                    check("beat_last", 64'(trace_last_o), 64'(exp_beat[32]));
                end
            end else if (trace_valid_o) begin
                hold_v = 1'b1;
                hold_d = {trace_last_o, trace_data_o};
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    // Drives one retirement for one cycle; call and return at posedge+1.
    task automatic retire(input logic [7:0] ord, input logic [31:0] pc, input logic [31:0] insn,
                          input logic [4:0] rd, input logic [31:0] wd, input logic trap,
                          input logic intr, input logic [1:0] mode,
                          input bit exp_push, input bit exp_drop);
        rvfi_valid    = 1'b1;
        rvfi_order    = {56'hC0_FFEE_1234_5600, ord};
        rvfi_pc_rdata = pc;
        rvfi_insn     = insn;
        rvfi_rd_addr  = rd;
        rvfi_rd_wdata = wd;
        rvfi_trap     = trap;
        rvfi_intr     = intr;
        rvfi_mode     = mode;
        if (exp_push) begin
            exp_q.push_back({1'b0, hdr(ord, rd, trap, intr, mode, exp_drop)});
            exp_q.push_back({1'b0, pc});
            exp_q.push_back({1'b0, insn});
            exp_q.push_back({1'b1, (rd == 5'd0) ? 32'd0 : wd});
        end
        @(posedge clk_i);
        #1;
        rvfi_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int cyc = 0;
        while (!(fifo_empty_o && !trace_valid_o) && cyc < 300) begin
            @(negedge clk_i);
            cyc++;
        end
        if (cyc >= 300) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: FIFO still busy after %0d cycles, expected drained", name, cyc);
        end
        check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] single_beats [4];

    initial begin
        rst_i = 1'b1; trace_en_i = 1'b1; rvfi_valid = 1'b0; rvfi_order = '0;
        rvfi_insn = '0; rvfi_trap = 1'b0; rvfi_intr = 1'b0; rvfi_mode = '0;
        rvfi_rd_addr = '0; rvfi_rd_wdata = '0; rvfi_pc_rdata = '0;
        trace_ready_i = 1'b1; drop_cnt_clr_i = 1'b0;

        // Reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_valid", 64'(trace_valid_o), 64'd0);
        check("rst_last", 64'(trace_last_o), 64'd0);
        check("rst_data", 64'(trace_data_o), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt_o), 64'd0);
        check("rst_empty", 64'(fifo_empty_o), 64'd1);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Single record with hand-computed beats and per-cycle latency
        single_beats[0] = 32'h0508_4000;
        single_beats[1] = 32'h8000_0100;
        single_beats[2] = 32'h0010_0093;
        single_beats[3] = 32'h0000_0001;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({(k == 3), single_beats[k]});
        end
        retire(8'd5, 32'h8000_0100, 32'h0010_0093, 5'd1, 32'h1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            check("single_valid", 64'(trace_valid_o), 64'd1);
            check("single_data", 64'(trace_data_o), 64'(single_beats[k]));
            check("single_last", 64'(trace_last_o), 64'(k == 3));
        end
        @(negedge clk_i);
        check("single_idle_valid", 64'(trace_valid_o), 64'd0);
        check("single_idle_empty", 64'(fifo_empty_o), 64'd1);
        @(posedge clk_i);
        #1;

        // Back-pressure at beat 2, then resume into the next record
        trace_ready_i = 1'b0;
        retire(8'h10, 32'h0000_2000, 32'hABCD_0013, 5'd31, 32'hFFFF_FFFF, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0);
        retire(8'hFF, 32'h0000_2004, 32'h0000_0073, 5'd0, 32'h1234_5678, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
        trace_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        trace_ready_i = 1'b0;
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        check("bp_valid", 64'(trace_valid_o), 64'd1);
        check("bp_data_beat2", 64'(trace_data_o), 64'h0000_0000_ABCD_0013);
        check("bp_last", 64'(trace_last_o), 64'd0);
        @(posedge clk_i);
        #1;
        trace_ready_i = 1'b1;
        wait_drain("bp");

        // Overflow: 12 retirements into an 8-deep FIFO with the sink stalled
        trace_ready_i = 1'b0;
        for (int i = 0; i < 12; i++) begin
            retire(8'(i + 1), 32'h1000_0000 + 32'(i * 4), 32'h0000_0013 | (32'(i) << 7),
                   5'(i), 32'hA5A5_0000 + 32'(i), i[0], i[1], 2'b11, (i < 8), 1'b0);
        end
        @(negedge clk_i);
        check("ovf_drop_cnt", 64'(drop_cnt_o), 64'd4);
        check("ovf_not_empty", 64'(fifo_empty_o), 64'd0);
        @(posedge clk_i);
        #1;
        trace_ready_i = 1'b1;
        wait_drain("ovf");
        retire(8'h40, 32'h3000_0000, 32'h0000_1111, 5'd7, 32'h0000_00AA, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1);
        retire(8'h41, 32'h3000_0004, 32'h0000_2222, 5'd8, 32'h0000_00BB, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
        wait_drain("ovf_flag");
        drop_cnt_clr_i = 1'b1;
        @(posedge clk_i);
        #1;
        drop_cnt_clr_i = 1'b0;
        check("clr_drop_cnt", 64'(drop_cnt_o), 64'd0);

        // Full FIFO: clear+drop in one cycle, then push alongside a beat-3 pop
        trace_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            retire(8'(8'h60 + i), 32'h4000_0000 + 32'(i * 4), 32'h0000_0033 + 32'(i),
                   5'(i + 3), 32'h0BAD_0000 + 32'(i), 1'b0, 1'b1, 2'b00, 1'b1, 1'b0);
        end
        drop_cnt_clr_i = 1'b1;
        retire(8'h70, 32'h5000_0000, 32'h0000_0001, 5'd1, 32'h1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        drop_cnt_clr_i = 1'b0;
        check("clr_with_drop_cnt", 64'(drop_cnt_o), 64'd1);
        trace_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        retire(8'h71, 32'h5000_0004, 32'h0000_0002, 5'd2, 32'h2, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1);
        check("full_pop_drop_cnt", 64'(drop_cnt_o), 64'd1);
        wait_drain("full_pop");

        // Enable gating: no capture and no drop counting while disabled
        trace_ready_i = 1'b0;
        retire(8'h80, 32'h6000_0000, 32'h0000_0A00, 5'd9, 32'h9, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
        retire(8'h81, 32'h6000_0004, 32'h0000_0A01, 5'd10, 32'hA, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
        trace_en_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            retire(8'(8'h90 + i), 32'h7000_0000 + 32'(i), 32'h0000_0B00, 5'd4, 32'h4,
                   1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        end
        check("gate_drop_cnt", 64'(drop_cnt_o), 64'd1);
        trace_ready_i = 1'b1;
        wait_drain("gate");
        trace_en_i = 1'b1;

        // Reset while presenting beat 1
        trace_ready_i = 1'b0;
        for (int i = 0; i < 9; i++) begin
            retire(8'(8'hA0 + i), 32'h9000_0000 + 32'(i * 4), 32'h0000_0C00 + 32'(i),
                   5'(i + 1), 32'h0000_C000 + 32'(i), 1'b0, 1'b0, 2'b10, (i < 8), 1'b0);
        end
        check("pre_rst_drop_cnt", 64'(drop_cnt_o), 64'd2);
        trace_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        trace_ready_i = 1'b0;
        exp_q.delete();
        @(posedge clk_i);
        @(negedge clk_i);
        check("midrst_valid", 64'(trace_valid_o), 64'd0);
        check("midrst_empty", 64'(fifo_empty_o), 64'd1);
        check("midrst_drop_cnt", 64'(drop_cnt_o), 64'd0);
        check("midrst_last", 64'(trace_last_o), 64'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        trace_ready_i = 1'b1;
        retire(8'hB0, 32'hA000_0000, 32'h0000_0D00, 5'd12, 32'h0000_D00D, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0);
        @(negedge clk_i);
        check("post_rst_beat0", 64'(trace_data_o), 64'(hdr(8'hB0, 5'd12, 1'b0, 1'b1, 2'b01, 1'b0)));
        @(posedge clk_i);
        #1;
        wait_drain("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
